// File: rtl/sips4_pkg.sv
// SIPS4 shared definitions: opcodes, controller states,
// instruction field positions and decode helpers.
package sips4_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_MOV  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_BZ   = 4'hA;
  localparam logic [3:0] OP_BNZ  = 4'hB;
  localparam logic [3:0] OP_BC   = 4'hC;
  localparam logic [3:0] OP_OUT  = 4'hD;
  localparam logic [3:0] OP_RSV  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int A_MSB  = 11;
  localparam int A_LSB  = 8;
  localparam int B_MSB  = 7;
  localparam int B_LSB  = 4;
  localparam int C_MSB  = 3;
  localparam int C_LSB  = 0;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_READ_B,
    S_READ_C,
    S_EXEC,
    S_HALT
  } state_t;

  function automatic logic reads_b(
    input logic [3:0] op
  );
    return !(op inside {OP_NOP, OP_LDI, OP_JMP,
                        OP_BC, OP_RSV, OP_HALT});
  endfunction

  function automatic logic reads_c(
    input logic [3:0] op
  );
    return op inside {OP_ADD, OP_SUB, OP_AND,
                      OP_OR, OP_XOR};
  endfunction

  function automatic logic writes_ram(
    input logic [3:0] op
  );
    return op inside {OP_LDI, OP_ADD, OP_SUB,
                      OP_AND, OP_OR, OP_XOR,
                      OP_ADDI, OP_MOV};
  endfunction

endpackage

// File: rtl/sips4_alu.sv
// SIPS4 combinational ALU: 4-bit result, carry/borrow
// and a zero flag on the result.
import sips4_pkg::*;

module sips4_alu (
  input  logic [3:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_in,
  output logic [3:0] result,
  output logic       carry_out,
  output logic       zero
);

  logic [4:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  // Non-arithmetic ops pass a through and keep carry
  always_comb begin
    result    = a;
    carry_out = carry_in;
    case (op)
      OP_LDI: result = b;
      OP_ADD,
      OP_ADDI: {carry_out, result} = sum;
      OP_SUB: begin
        result    = a - b;
        carry_out = (a < b);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      default: ;
    endcase
  end

  assign zero = (result == 4'h0);

endmodule

// File: rtl/sips4_exec_unit.sv
// SIPS4 fetch/decode/execute controller sequencing the
// synchronous instruction ROM and 16x4 data RAM.
import sips4_pkg::*;

module sips4_exec_unit #(
  parameter logic [3:0] RESET_PC = 4'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  rom_addr,
  input  logic [15:0] rom_q,
  output logic [3:0]  ram_raddr,
  input  logic [3:0]  ram_rdata,
  output logic [3:0]  ram_waddr,
  output logic [3:0]  ram_wdata,
  output logic        ram_wen,
  output logic [3:0]  out_data,
  output logic        out_valid,
  output logic        halted
);

  state_t      state;
  logic [3:0]  pc;
  logic [15:0] ir;
  logic [3:0]  opb;
  logic [3:0]  opc;
  logic        carry;

  logic [3:0]  op;
  logic [3:0]  fa;
  logic [3:0]  fb;
  logic [3:0]  fc;
  logic [3:0]  dec_op;
  logic [3:0]  alu_b;
  logic [3:0]  alu_res;
  logic        alu_carry;
  logic        alu_zero;
  logic        taken;

  assign op     = ir[OP_MSB:OP_LSB];
  assign fa     = ir[A_MSB:A_LSB];
  assign fb     = ir[B_MSB:B_LSB];
  assign fc     = ir[C_MSB:C_LSB];
  assign dec_op = rom_q[OP_MSB:OP_LSB];

  // C is an immediate unless the op read a second word
  assign alu_b = reads_c(op) ? opc : fc;

  sips4_alu u_alu (
    .op        (op),
    .a         (opb),
    .b         (alu_b),
    .carry_in  (carry),
    .result    (alu_res),
    .carry_out (alu_carry),
    .zero      (alu_zero)
  );

  always_comb begin
    taken = 1'b0;
    case (op)
      OP_JMP: taken = 1'b1;
      OP_BZ:  taken = alu_zero;
      OP_BNZ: taken = !alu_zero;
      OP_BC:  taken = carry;
      default: ;
    endcase
  end

  always_comb begin
    ram_raddr = fb;
    unique case (1'b1)
      state == S_DECODE: ram_raddr = rom_q[B_MSB:B_LSB];
      state == S_READ_B: ram_raddr = fc;
      default: ;
    endcase
  end

  assign rom_addr  = pc;
  assign ram_waddr = fa;
  assign ram_wdata = alu_res;
  assign ram_wen   = (state == S_EXEC) && writes_ram(op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      ir        <= 16'h0000;
      opb       <= 4'h0;
      opc       <= 4'h0;
      carry     <= 1'b0;
      out_data  <= 4'h0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          ir    <= rom_q;
          state <= reads_b(dec_op) ? S_READ_B : S_EXEC;
        end
        S_READ_B: begin
          opb   <= ram_rdata;
          state <= reads_c(op) ? S_READ_C : S_EXEC;
        end
        S_READ_C: begin
          opc   <= ram_rdata;
          state <= S_EXEC;
        end
        S_EXEC: begin
          pc    <= taken ? fc : pc + 4'd1;
          carry <= alu_carry;
          if (op == OP_OUT) begin
            out_data  <= opb;
            out_valid <= 1'b1;
          end
          if (op == OP_HALT) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            state  <= S_FETCH;
          end
        end
        S_HALT: ;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_sips4_exec_unit.sv
// Directed bench for sips4_exec_unit with behavioural
// synchronous ROM and RAM models.
module tb_sips4_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  rom_addr;
  logic [15:0] rom_q;
  logic [3:0]  ram_raddr;
  logic [3:0]  ram_rdata;
  logic [3:0]  ram_waddr;
  logic [3:0]  ram_wdata;
  logic        ram_wen;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        halted;

  logic [15:0] rom [16];
  logic [3:0]  mem [16];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_a = 4'h0;
  logic [3:0]  pre_d = 4'h0;

  int checks = 0;
  int failures = 0;

  int         n;
  logic [3:0] a;
  logic [3:0] d;
  logic [3:0] ha;
  int         bad;

  always #10 clk = ~clk;

  sips4_exec_unit #(.RESET_PC(4'h0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_wen   (ram_wen),
    .out_data  (out_data),
    .out_valid (out_valid),
    .halted    (halted)
  );

  always @(posedge clk) begin
    rom_q     <= rom[rom_addr];
    ram_rdata <= mem[ram_raddr];
    if (pre_we)
      mem[pre_a] <= pre_d;
    else if (ram_wen)
      mem[ram_waddr] <= ram_wdata;
  end

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
  endtask

  task automatic start();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_write(output int cnt,
                            output logic [3:0] wa,
                            output logic [3:0] wd);
    cnt = 0;
    while (ram_wen !== 1'b1 && cnt < 16) begin
      @(negedge clk);
      cnt++;
    end
    wa = ram_waddr;
    wd = ram_wdata;
  endtask

  task automatic exp_write(input string tag,
                           input int lat,
                           input logic [3:0] ea,
                           input logic [3:0] ed);
    int         c;
    logic [3:0] wa;
    logic [3:0] wd;
    wait_write(c, wa, wd);
    chk({tag, "_lat"}, 16'(c), 16'(lat));
    chk({tag, "_addr"}, wa, ea);
    chk({tag, "_data"}, wd, ed);
    @(negedge clk);
  endtask

  initial begin
    // basic program, reset state
    clear_rom();
    rom[0] = 16'h1105;
    rom[1] = 16'h1203;
    rom[2] = 16'h2312;
    rom[3] = 16'hC00A;
    step(2);
    chk("rst_pc", rom_addr, 4'h0);
    chk("rst_wen", ram_wen, 1'b0);
    chk("rst_out", out_data, 4'h0);
    chk("rst_oval", out_valid, 1'b0);
    chk("rst_halt", halted, 1'b0);
    rst_n = 1'b1;
    chk("t1_pc0", rom_addr, 4'h0);
    exp_write("t1_ldi1", 2, 4'h1, 4'h5);
    chk("t1_pc1", rom_addr, 4'h1);
    exp_write("t1_ldi2", 2, 4'h2, 4'h3);
    chk("t1_pc2", rom_addr, 4'h2);
    exp_write("t1_add", 4, 4'h3, 4'h8);
    chk("t1_pc3", rom_addr, 4'h3);
    chk("t1_m1", mem[1], 4'h5);
    chk("t1_m2", mem[2], 4'h3);
    chk("t1_m3", mem[3], 4'h8);
    step(3);
    chk("t1_bc_nt", rom_addr, 4'h4);

    // carry from ADD drives BC
    rst_n = 1'b0;
    clear_rom();
    rom[0] = 16'h1109;
    rom[1] = 16'h1209;
    rom[2] = 16'h2312;
    rom[3] = 16'hC00A;
    start();
    exp_write("t2_ldi1", 2, 4'h1, 4'h9);
    exp_write("t2_ldi2", 2, 4'h2, 4'h9);
    exp_write("t2_add", 4, 4'h3, 4'h2);
    step(3);
    chk("t2_bc_t", rom_addr, 4'hA);

    // SUB borrow, then no borrow with wrap at 15
    rst_n = 1'b0;
    clear_rom();
    rom[0]  = 16'h1103;
    rom[1]  = 16'h1205;
    rom[2]  = 16'h3412;
    rom[3]  = 16'hC00C;
    rom[12] = 16'h1105;
    rom[13] = 16'h1203;
    rom[14] = 16'h3412;
    rom[15] = 16'hC007;
    start();
    exp_write("t3_ldi1", 2, 4'h1, 4'h3);
    exp_write("t3_ldi2", 2, 4'h2, 4'h5);
    exp_write("t3_sub1", 4, 4'h4, 4'hE);
    step(3);
    chk("t3_borrow", rom_addr, 4'hC);
    exp_write("t3_ldi3", 2, 4'h1, 4'h5);
    exp_write("t3_ldi4", 2, 4'h2, 4'h3);
    exp_write("t3_sub2", 4, 4'h4, 4'h2);
    step(3);
    chk("t3_noborrow", rom_addr, 4'h0);

    // BZ / BNZ / JMP / wrap
    rst_n = 1'b0;
    clear_rom();
    rom[0]  = 16'h1500;
    rom[1]  = 16'hA056;
    rom[6]  = 16'hB059;
    rom[7]  = 16'h900F;
    rom[15] = 16'h0000;
    start();
    exp_write("t4_ldi", 2, 4'h5, 4'h0);
    chk("t4_pc1", rom_addr, 4'h1);
    step(4);
    chk("t4_bz", rom_addr, 4'h6);
    step(4);
    chk("t4_bnz", rom_addr, 4'h7);
    step(3);
    chk("t4_jmp", rom_addr, 4'hF);
    step(3);
    chk("t4_wrap", rom_addr, 4'h0);

    // OUT then HALT
    rst_n = 1'b0;
    clear_rom();
    rom[0] = 16'h1607;
    rom[1] = 16'hD060;
    rom[2] = 16'hF000;
    start();
    exp_write("t5_ldi", 2, 4'h6, 4'h7);
    chk("t5_oval0", out_valid, 1'b0);
    step(4);
    chk("t5_oval1", out_valid, 1'b1);
    chk("t5_out", out_data, 4'h7);
    step(1);
    chk("t5_oval2", out_valid, 1'b0);
    chk("t5_out2", out_data, 4'h7);
    step(1);
    chk("t5_halt0", halted, 1'b0);
    step(1);
    chk("t5_halt1", halted, 1'b1);
    ha  = rom_addr;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (rom_addr !== ha || ram_wen !== 1'b0 ||
          halted !== 1'b1 || out_valid !== 1'b0)
        bad++;
    end
    chk("t5_halt_stable", 16'(bad), 16'h0);

    // asynchronous reset in the middle of ADD's EXEC
    rst_n  = 1'b0;
    pre_we = 1'b1;
    pre_a  = 4'h7;
    pre_d  = 4'hA;
    step(1);
    pre_we = 1'b0;
    clear_rom();
    rom[0] = 16'h1104;
    rom[1] = 16'h1204;
    rom[2] = 16'h2712;
    start();
    exp_write("t6_ldi1", 2, 4'h1, 4'h4);
    exp_write("t6_ldi2", 2, 4'h2, 4'h4);
    wait_write(n, a, d);
    chk("t6_exec_lat", 16'(n), 16'h4);
    chk("t6_exec_wen", ram_wen, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_wen_drop", ram_wen, 1'b0);
    chk("t6_pc_rst", rom_addr, 4'h0);
    step(1);
    chk("t6_m7", mem[7], 4'hA);
    start();
    chk("t6_pc_rel", rom_addr, 4'h0);
    exp_write("t6_restart", 2, 4'h1, 4'h4);
    chk("t6_m7_after", mem[7], 4'hA);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
